// File: rtl/glide_pkg.sv
// Shared types and constants for the glide scheduler.
// Used by both step modes; the mode is selected with GLIDE_SCHED_EXP_EN.
package glide_pkg;

   typedef enum logic {
      GS_IDLE,
      GS_SWEEP
   } glide_sched_state_e;

   localparam int GLIDE_EXP_SHIFT_W = 4;

endpackage

// File: rtl/glide_step.sv
// Combinational single-voice glide step: moves cur toward tgt without overshoot or wrap.
// GLIDE_SCHED_EXP_EN selects exponential glide (step = max(|diff| >> rate[3:0], 1)); default is linear.
module glide_step
   import glide_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] tgt,
   input  logic [WIDTH-1:0] rate,
   output logic [WIDTH-1:0] next
);

   logic             up;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] step;

   // Compare the distance to target with the step, so the sum never leaves the range
   always_comb begin
      up   = (cur < tgt);
      diff = up ? (tgt - cur) : (cur - tgt);
`ifdef GLIDE_SCHED_EXP_EN
      step = diff >> rate[GLIDE_EXP_SHIFT_W-1:0];
      if (step == '0) begin
         step = WIDTH'(1);
      end
`else
      step = rate;
`endif
      if (cur == tgt) begin
         next = cur;
      end else if (diff > step) begin
         next = up ? (cur + step) : (cur - step);
      end else begin
         next = tgt;
      end
   end

endmodule

// File: rtl/glide_scheduler.sv
// Round-robin glide scheduler: one shared glide_step unit sweeps all voices once per tick.
// Step mode follows GLIDE_SCHED_EXP_EN (exponential when defined, linear otherwise).
module glide_scheduler
   import glide_pkg::*;
#(
   parameter  int WIDTH   = 16,
   parameter  int NVOICES = 4,
   localparam int VIDX_W  = $clog2(NVOICES)
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               tick,
   input  logic [WIDTH-1:0]   rate,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [VIDX_W-1:0]  cfg_voice,
   input  logic [WIDTH-1:0]   cfg_target,
   input  logic               cfg_snap,
   output logic               freq_valid,
   output logic [VIDX_W-1:0]  freq_voice,
   output logic [WIDTH-1:0]   freq_out,
   output logic               busy,
   output logic [NVOICES-1:0] settled,
   output logic               overrun
);

   glide_sched_state_e state, state_next;

   logic [WIDTH-1:0]  current [NVOICES];
   logic [WIDTH-1:0]  target  [NVOICES];
   logic [VIDX_W-1:0] index;
   logic              pending;
   logic              last_voice;
   logic [WIDTH-1:0]  step_next;

   assign last_voice = (index == VIDX_W'(NVOICES - 1));

   glide_step #(.WIDTH(WIDTH)) u_step (
      .cur  (current[index]),
      .tgt  (target[index]),
      .rate (rate),
      .next (step_next)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= GS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A sweep always returns to IDLE for at least one cycle so writes are never starved
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      cfg_ready  = 1'b0;
      case (state)
         GS_IDLE: begin
            cfg_ready = 1'b1;
            if (tick || pending) begin
               state_next = GS_SWEEP;
            end
         end
         GS_SWEEP: begin
            busy = 1'b1;
            if (last_voice) begin
               state_next = GS_IDLE;
            end
         end
         default: state_next = GS_IDLE;
      endcase
   end

   // A tick that finds one already pending is lost and latches overrun
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int v = 0; v < NVOICES; v++) begin
            current[v] <= '0;
            target[v]  <= '0;
         end
         index      <= '0;
         pending    <= 1'b0;
         overrun    <= 1'b0;
         freq_valid <= 1'b0;
         freq_voice <= '0;
         freq_out   <= '0;
      end else begin
         freq_valid <= 1'b0;
         case (state)
            GS_IDLE: begin
               index <= '0;
               if (pending) begin
                  pending <= 1'b0;
                  if (tick) begin
                     overrun <= 1'b1;
                  end
               end
               if (cfg_valid && (int'(cfg_voice) < NVOICES)) begin
                  target[cfg_voice] <= cfg_target;
                  if (cfg_snap) begin
                     current[cfg_voice] <= cfg_target;
                  end
               end
            end
            GS_SWEEP: begin
               current[index] <= step_next;
               freq_out       <= step_next;
               freq_voice     <= index;
               freq_valid     <= 1'b1;
               index          <= last_voice ? '0 : index + 1'b1;
               if (tick) begin
                  if (pending) begin
                     overrun <= 1'b1;
                  end else begin
                     pending <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      settled = '0;
      for (int v = 0; v < NVOICES; v++) begin
         settled[v] = (current[v] == target[v]);
      end
   end

endmodule
